// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch and load/store ports onto one single-ported memory bus.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; the default build uses fixed data priority.
module mem_port_arbiter #(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_valid,
    output logic        i_err,
    output logic [31:0] i_data,
    input  logic        d_r_req,
    input  logic        d_w_req,
    input  logic        d_ext,
    input  logic [1:0]  d_width,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_valid,
    output logic        d_err,
    output logic [31:0] d_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t          state;
    logic [TO_W-1:0] cnt;
    logic            lat_is_data;
    logic            lat_store;
    logic [1:0]      lat_width;
    logic            lat_ext;
    logic [1:0]      lat_off;
`ifdef ARB_ROUND_ROBIN_EN
    logic            last_data;
`endif

    logic        data_pend;
    logic        grant_data;
    logic        grant_fetch;
    logic        d_misal;
    logic        i_misal;
    logic [3:0]  st_strb;
    logic [31:0] st_wdata;
    logic [31:0] shifted;
    logic [31:0] load_data;

    always_comb begin
        data_pend = d_r_req | d_w_req;
`ifdef ARB_ROUND_ROBIN_EN
        // Fetch wins a tie only when data was the previous grant.
        grant_data = data_pend & (~i_req | ~last_data);
`else
        grant_data = data_pend;
`endif
        grant_fetch = i_req & ~grant_data;
        d_misal = (d_width == 2'd3) ||
                  ((d_width == 2'd1) && d_addr[0]) ||
                  ((d_width == 2'd2) && (d_addr[1:0] != 2'b00));
        i_misal = (i_addr[1:0] != 2'b00);
    end

    always_comb begin
        st_strb  = 4'b1111;
        st_wdata = d_wdata;
        case (d_width)
            2'd0: begin
                st_strb  = 4'b0001 << d_addr[1:0];
                st_wdata = {4{d_wdata[7:0]}};
            end
            2'd1: begin
                st_strb  = 4'b0011 << d_addr[1:0];
                st_wdata = {2{d_wdata[15:0]}};
            end
            default: begin
                st_strb  = 4'b1111;
                st_wdata = d_wdata;
            end
        endcase
    end

    always_comb begin
        shifted   = mem_rdata >> {lat_off, 3'b000};
        load_data = shifted;
        case (lat_width)
            2'd0:    load_data = lat_ext ? {24'b0, shifted[7:0]}
                                         : {{24{shifted[7]}}, shifted[7:0]};
            2'd1:    load_data = lat_ext ? {16'b0, shifted[15:0]}
                                         : {{16{shifted[15]}}, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            lat_is_data <= 1'b0;
            lat_store   <= 1'b0;
            lat_width   <= 2'd0;
            lat_ext     <= 1'b0;
            lat_off     <= 2'd0;
`ifdef ARB_ROUND_ROBIN_EN
            last_data   <= 1'b0;
`endif
            i_valid     <= 1'b0;
            i_err       <= 1'b0;
            i_data      <= '0;
            d_valid     <= 1'b0;
            d_err       <= 1'b0;
            d_rdata     <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wstrb   <= 4'b0000;
            mem_wdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_data || grant_fetch) begin
                        lat_is_data <= grant_data;
                        lat_store   <= grant_data & d_w_req;
                        lat_width   <= d_width;
                        lat_ext     <= d_ext;
                        lat_off     <= d_addr[1:0];
`ifdef ARB_ROUND_ROBIN_EN
                        last_data   <= grant_data;
`endif
                        // Misaligned accesses never reach the memory bus.
                        if (grant_data ? d_misal : i_misal) begin
                            state   <= RESP;
                            i_valid <= grant_fetch;
                            i_err   <= grant_fetch;
                            i_data  <= '0;
                            d_valid <= grant_data;
                            d_err   <= grant_data;
                            d_rdata <= '0;
                        end else begin
                            state     <= BUSY;
                            cnt       <= '0;
                            mem_req   <= 1'b1;
                            mem_we    <= grant_data & d_w_req;
                            mem_addr  <= grant_data ? {d_addr[31:2], 2'b00}
                                                    : {i_addr[31:2], 2'b00};
                            mem_wstrb <= (grant_data & d_w_req) ? st_strb : 4'b0000;
                            mem_wdata <= (grant_data & d_w_req) ? st_wdata : 32'd0;
                        end
                    end
                end
                BUSY: begin
                    cnt <= cnt + 1'b1;
                    if (mem_ready || (cnt == TO_W'(TIMEOUT - 1))) begin
                        state     <= RESP;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_wstrb <= 4'b0000;
                        mem_wdata <= '0;
                        i_valid   <= ~lat_is_data;
                        d_valid   <= lat_is_data;
                        i_err     <= ~lat_is_data & ~mem_ready;
                        d_err     <= lat_is_data & ~mem_ready;
                        i_data    <= (~lat_is_data & mem_ready) ? mem_rdata : 32'd0;
                        d_rdata   <= (lat_is_data & ~lat_store & mem_ready) ? load_data : 32'd0;
                    end
                end
                RESP: begin
                    state   <= IDLE;
                    i_valid <= 1'b0;
                    i_err   <= 1'b0;
                    i_data  <= '0;
                    d_valid <= 1'b0;
                    d_err   <= 1'b0;
                    d_rdata <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed cases then randomized traffic against a behavioural model.
module tb_mem_port_arbiter;

    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_valid;
    logic        i_err;
    logic [31:0] i_data;
    logic        d_r_req;
    logic        d_w_req;
    logic        d_ext;
    logic [1:0]  d_width;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_valid;
    logic        d_err;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    int vectors     = 0;
    int miscompares = 0;
    bit last_data   = 1'b0;

    mem_port_arbiter #(.TIMEOUT(TIMEOUT), .TO_W(3)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_valid(i_valid), .i_err(i_err), .i_data(i_data),
        .d_r_req(d_r_req), .d_w_req(d_w_req), .d_ext(d_ext), .d_width(d_width),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_valid(d_valid), .d_err(d_err), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic bit model_misaligned(bit is_data, logic [31:0] addr, logic [1:0] width);
        if (!is_data) return (addr % 4) != 0;
        if (width == 2'd3) return 1'b1;
        return (addr % (32'd1 << width)) != 0;
    endfunction

    function automatic logic [31:0] model_load(logic [31:0] rdata, logic [31:0] addr,
                                               logic [1:0] width, logic ext);
        longint off  = longint'(addr % 4);
        longint size = longint'(1) << width;
        longint v    = longint'(rdata >> (8 * off));
        if (size < 4) begin
            v = v % (longint'(1) << (8 * size));
            if (!ext && v >= (longint'(1) << (8 * size - 1)))
                v = v - (longint'(1) << (8 * size));
        end
        return 32'(v);
    endfunction

    function automatic logic [3:0] model_strb(logic [31:0] addr, logic [1:0] width);
        logic [3:0] s = 4'b0000;
        int off  = int'(addr % 4);
        int size = 1 << width;
        for (int i = 0; i < 4; i++)
            if (i >= off && i < off + size) s[i] = 1'b1;
        return s;
    endfunction

    function automatic logic [31:0] model_wdata(logic [31:0] wdata, logic [1:0] width);
        logic [31:0] w = '0;
        int size = 1 << width;
        for (int i = 0; i < 4; i++)
            w[8*i +: 8] = wdata[8*(i % size) +: 8];
        return w;
    endfunction

    // kind: 0 fetch, 1 load, 2 store, 3 load+store together (served as a store).
    // waits: busy cycles before mem_ready, negative means memory never answers.
    task automatic applyStimulus(input int kind, input logic [31:0] addr, input logic [1:0] width,
                                 input logic ext, input logic [31:0] wdata,
                                 input logic [31:0] rdata, input int waits);
        bit          is_data  = (kind != 0);
        bit          is_store = (kind >= 2);
        bit          misal    = model_misaligned(is_data, addr, width);
        bit          answers  = (waits >= 0) && (waits < TIMEOUT);
        bit          exp_err  = misal || !answers;
        logic [31:0] exp_data;
        int          exp_cycle;
        int          exp_busy;
        int          cycle = 0;
        int          busy  = 0;
        bit          got   = 1'b0;

        if (exp_err || is_store) exp_data = 32'd0;
        else if (is_data)        exp_data = model_load(rdata, addr, width, ext);
        else                     exp_data = rdata;
        exp_busy  = misal ? 0 : (answers ? waits + 1 : TIMEOUT);
        exp_cycle = misal ? 1 : exp_busy + 1;

        @(negedge clk);
        i_req     = !is_data;
        i_addr    = addr;
        d_r_req   = (kind == 1) || (kind == 3);
        d_w_req   = (kind >= 2);
        d_addr    = addr;
        d_width   = width;
        d_ext     = ext;
        d_wdata   = wdata;
        mem_ready = 1'b0;

        while (!got && cycle < 40) begin
            @(negedge clk);
            cycle++;
            if (i_valid || d_valid) begin
                got = 1'b1;
            end else if (mem_req) begin
                if (busy == 0) begin
                    checkOutput("mem_addr", mem_addr, {addr[31:2], 2'b00});
                    checkOutput("mem_we", 32'(mem_we), 32'(is_store));
                    checkOutput("mem_wstrb", 32'(mem_wstrb), is_store ? 32'(model_strb(addr, width)) : 32'd0);
                    if (is_store) checkOutput("mem_wdata", mem_wdata, model_wdata(wdata, width));
                end
                if (busy == waits) begin
                    mem_ready = 1'b1;
                    mem_rdata = rdata;
                end else begin
                    mem_ready = 1'b0;
                    mem_rdata = $urandom;
                end
                busy++;
            end else begin
                mem_ready = 1'b0;
                mem_rdata = $urandom;
            end
        end

        if (!got) begin
            checkOutput("no_response", 32'd0, 32'd1);
        end else begin
            checkOutput("latency", cycle, exp_cycle);
            checkOutput("busy_cycles", busy, exp_busy);
            checkOutput("i_valid", 32'(i_valid), 32'(!is_data));
            checkOutput("d_valid", 32'(d_valid), 32'(is_data));
            checkOutput("mem_req_resp", 32'(mem_req), 32'd0);
            if (is_data) begin
                checkOutput("d_err", 32'(d_err), 32'(exp_err));
                checkOutput("d_rdata", d_rdata, exp_data);
            end else begin
                checkOutput("i_err", 32'(i_err), 32'(exp_err));
                checkOutput("i_data", i_data, exp_data);
            end
        end
        last_data = is_data;

        i_req     = 1'b0;
        d_r_req   = 1'b0;
        d_w_req   = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        checkOutput("pulse_width", 32'(i_valid | d_valid), 32'd0);
    endtask

    task automatic contention();
        bit          exp_data_first;
        int          served = 0;
        int          cycle  = 0;
        bit          order[2];
        logic [31:0] fetch_word = 32'h1111_2222;
        logic [31:0] data_word  = 32'hA5A5_0F0F;

`ifdef ARB_ROUND_ROBIN_EN
        exp_data_first = !last_data;
`else
        exp_data_first = 1'b1;
`endif
        @(negedge clk);
        i_req     = 1'b1;
        i_addr    = 32'h0000_0100;
        d_r_req   = 1'b1;
        d_w_req   = 1'b0;
        d_width   = 2'd2;
        d_ext     = 1'b0;
        d_addr    = 32'h0000_0200;
        mem_ready = 1'b1;
        mem_rdata = '0;
        while (served < 2 && cycle < 40) begin
            @(negedge clk);
            cycle++;
            mem_rdata = (mem_addr == 32'h0000_0200) ? data_word : fetch_word;
            if (d_valid) begin
                checkOutput("cont_d_rdata", d_rdata, data_word);
                order[served] = 1'b1;
                served++;
                d_r_req = 1'b0;
            end else if (i_valid) begin
                checkOutput("cont_i_data", i_data, fetch_word);
                order[served] = 1'b0;
                served++;
                i_req = 1'b0;
            end
        end
        checkOutput("cont_served", served, 2);
        if (served == 2) begin
            checkOutput("cont_first", 32'(order[0]), 32'(exp_data_first));
            checkOutput("cont_second", 32'(order[1]), 32'(!exp_data_first));
            last_data = order[1];
        end
        i_req     = 1'b0;
        d_r_req   = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic resetInBusy();
        int cycle = 0;
        @(negedge clk);
        i_req     = 1'b1;
        i_addr    = 32'h0000_0040;
        mem_ready = 1'b0;
        while (!mem_req && cycle < 5) begin
            @(negedge clk);
            cycle++;
        end
        checkOutput("rst_busy_reached", 32'(mem_req), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
        checkOutput("rst_mem_addr", mem_addr, 32'd0);
        checkOutput("rst_valids", 32'({i_valid, d_valid, i_err, d_err}), 32'd0);
        checkOutput("rst_data", i_data | d_rdata, 32'd0);
        rst   = 1'b0;
        i_req = 1'b0;
        last_data = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("rst_no_pulse", 32'({i_valid, d_valid, mem_req}), 32'd0);
        end
    endtask

    initial begin
        rst       = 1'b1;
        i_req     = 1'b0;
        i_addr    = '0;
        d_r_req   = 1'b0;
        d_w_req   = 1'b0;
        d_ext     = 1'b0;
        d_width   = 2'd0;
        d_addr    = '0;
        d_wdata   = '0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset_mem", {mem_req, mem_we, mem_wstrb} | mem_addr | mem_wdata, 32'd0);
        checkOutput("reset_resp", 32'({i_valid, i_err, d_valid, d_err}) | i_data | d_rdata, 32'd0);
        rst = 1'b0;

        // Stray mem_ready while idle must not produce anything.
        mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("idle_ready_ignored", 32'({mem_req, i_valid, d_valid}), 32'd0);
        mem_ready = 1'b0;

        applyStimulus(0, 32'h0040_0004, 2'd2, 1'b0, 32'd0, 32'h0010_0093, 0);
        applyStimulus(1, 32'h0000_1003, 2'd0, 1'b0, 32'd0, 32'h80FF_FFFF, 0);
        applyStimulus(1, 32'h0000_1003, 2'd0, 1'b1, 32'd0, 32'h80FF_FFFF, 0);
        applyStimulus(2, 32'h0000_2002, 2'd1, 1'b0, 32'h0000_BEEF, 32'd0, 0);
        applyStimulus(1, 32'h0000_1002, 2'd2, 1'b0, 32'd0, 32'h1234_5678, 0);
        applyStimulus(0, 32'h0000_0302, 2'd2, 1'b0, 32'd0, 32'h1234_5678, 0);
        applyStimulus(0, 32'h0000_0800, 2'd2, 1'b0, 32'd0, 32'hDEAD_BEEF, -1);
        applyStimulus(0, 32'h0000_0804, 2'd2, 1'b0, 32'd0, 32'hCAFE_F00D, TIMEOUT - 1);
        applyStimulus(3, 32'h0000_3001, 2'd0, 1'b0, 32'h0000_00C3, 32'd0, 1);
        applyStimulus(1, 32'h0000_4002, 2'd1, 1'b0, 32'd0, 32'h8001_7FFF, 2);
        contention();
        applyStimulus(0, 32'h0000_0900, 2'd2, 1'b0, 32'd0, 32'h0BAD_F00D, 0);
        contention();
        resetInBusy();
        applyStimulus(0, 32'h0000_0A00, 2'd2, 1'b0, 32'd0, 32'h0000_0013, 1);

        for (int n = 0; n < 60; n++) begin
            int          kind  = $urandom_range(0, 3);
            logic [1:0]  width = 2'($urandom_range(0, 3));
            logic [31:0] addr  = $urandom;
            int          waits = $urandom_range(0, 5);
            if ($urandom_range(0, 3) != 0) begin
                if (kind == 0) addr[1:0] = 2'b00;
                else if (width == 2'd1) addr[0] = 1'b0;
                else if (width == 2'd2) addr[1:0] = 2'b00;
            end
            if (waits == 5) waits = -1;
            applyStimulus(kind, addr, width, 1'($urandom_range(0, 1)), $urandom, $urandom, waits);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
